pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Fetch-stage PC register and instruction-memory request controller. Holds the
//  program counter, drives it to the dedicated +4 and branch-target adders, and
//  selects the next PC from their results. Fetches from instruction memory with
//  a busy-wait handshake and delivers {PC, instruction} to the IF/ID register.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  TRAP_VECTOR   32'h0000_0100  misaligned-target handler address (PC_MISALIGN_TRAP_EN only)
// PORTS
//  CLK            in   1   clock, all state on posedge
//  RESET          in   1   asynchronous, active-low reset
//  PC             out  32  current PC, to +4 adder and branch-target adder
//  PC_PLUS4       in   32  PC+4 from +4 adder
//  BRANCH_TARGET  in   32  PC+imm from branch adder (resolved in later stage)
//  BRANCH_TAKEN   in   1   redirect request, one cycle, qualifies BRANCH_TARGET
//  STALL          in   1   hazard-unit hold of IF stage
//  IMEM_READ      out  1   instruction memory read request
//  IMEM_ADDR      out  32  read address (= PC)
//  IMEM_BUSYWAIT  in   1   memory not ready; IMEM_RDATA valid when low while IMEM_READ high
//  IMEM_RDATA     in   32  instruction word
//  IF_VALID       out  1   IF_PC/IF_INSTR hold a live instruction this cycle
//  IF_PC          out  32  PC of delivered instruction
//  IF_INSTR       out  32  delivered instruction
//  MISALIGN_TRAP  out  1   present only with PC_MISALIGN_TRAP_EN
// BEHAVIOUR
//  - Reset (RESET=0, async): PC=RESET_VECTOR, state=FETCH, IMEM_READ=0,
//    IF_VALID=0, IF_PC=0, IF_INSTR=0, redirect_pending=0, MISALIGN_TRAP=0.
//    First request issues the cycle after RESET deasserts. Mid-transaction reset aborts it; no data delivered.
//  - IMEM_ADDR=PC always; IMEM_READ=1 in FETCH/WAIT, 0 in HOLD and reset.
//  - States: FETCH (request issued), WAIT (busywait seen), HOLD (instr captured, STALL high).
//    FETCH/WAIT & BUSYWAIT=1 -> WAIT; PC frozen, IF_VALID=0.
//    FETCH/WAIT & BUSYWAIT=0 -> capture: if STALL=0, IF_VALID=1 next cycle, PC<=next_pc, ->FETCH;
//    if STALL=1, hold captured word in buffer, ->HOLD.
//    HOLD & STALL=1 -> HOLD, outputs unchanged; HOLD & STALL=0 -> deliver, PC<=next_pc, ->FETCH.
//  - next_pc priority: redirect (BRANCH_TAKEN or redirect_pending) > PC_PLUS4.
//  - BRANCH_TAKEN in FETCH/HOLD: PC<=BRANCH_TARGET next edge regardless of STALL;
//    any captured/in-flight word squashed (IF_VALID=0), ->FETCH.
//  - BRANCH_TAKEN in WAIT: latch target, redirect_pending=1; when BUSYWAIT drops,
//    returned word discarded, PC<=latched target, pending cleared. A second BRANCH_TAKEN
//    while pending overwrites the latched target (youngest wins).
//  - IF_VALID is 1 for exactly one cycle per delivered instruction; STALL with no
//    capture keeps IF outputs stable. All PC arithmetic modulo 2^32 (0xFFFF_FFFC+4 -> 0).
//  - Zero-latency best case: one instruction per cycle when BUSYWAIT never asserts.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined: taken redirect with BRANCH_TARGET[1:0]!=0 loads
//    TRAP_VECTOR instead, MISALIGN_TRAP pulses 1 cycle, in-flight word squashed.
//  Undefined: port absent; BRANCH_TARGET[1:0] forced to 2'b00 silently.
// STRUCTURE
//  Shared package/header pc_fetch_defs: FSM state encoding (FETCH, WAIT, HOLD),
//    INSTR_NOP=32'h0000_0013, word width 32.
//  One sub-module: pc_redirect_ctrl (redirect_pending flag, latched target, squash signal).
//  PC register and FSM stay in top level.
// TESTING
//  - Reset release, BUSYWAIT=0, STALL=0 -> IMEM_ADDR 0,4,8,12 on consecutive cycles, IF_VALID=1 each.
//  - BUSYWAIT high 3 cycles at PC=8 -> PC held at 8, IF_VALID=0 3 cycles, then IF_PC=8.
//  - STALL high 2 cycles after capture of PC=4 -> IF_PC=4 held, IMEM_READ=0, PC stays 4 then 8.
//  - BRANCH_TAKEN target 0x40 during WAIT at PC=0x10 -> word for 0x10 dropped, next IMEM_ADDR=0x40.
//  - Taken to 0x42 with PC_MISALIGN_TRAP_EN -> PC=TRAP_VECTOR, MISALIGN_TRAP=1 one cycle; without -> PC=0x40.
//  - RESET low mid-WAIT at PC=0x20 -> PC=RESET_VECTOR immediately, IF_VALID=0, no stale delivery.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, word width and
// the canonical NOP encoding. Optional feature macro used by this block:
// PC_MISALIGN_TRAP_EN.
package pc_fetch_defs;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] INSTR_NOP = 32'h0000_0013;

    // FETCH: request issued, WAIT: memory reported busy, HOLD: word captured
    // while the hazard unit holds the stage.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bus bundle between the fetch unit and its surroundings (PC adders, branch
// resolution, hazard unit, instruction memory and the IF/ID register).
// master = fetch unit, slave = environment. MISALIGN_TRAP exists only when
// PC_MISALIGN_TRAP_EN is defined.
interface pc_fetch_unit_if;
    import pc_fetch_defs::*;

    logic [WORD_W-1:0] PC;
    logic [WORD_W-1:0] PC_PLUS4;
    logic [WORD_W-1:0] BRANCH_TARGET;
    logic              BRANCH_TAKEN;
    logic              STALL;
    logic              IMEM_READ;
    logic [WORD_W-1:0] IMEM_ADDR;
    logic              IMEM_BUSYWAIT;
    logic [WORD_W-1:0] IMEM_RDATA;
    logic              IF_VALID;
    logic [WORD_W-1:0] IF_PC;
    logic [WORD_W-1:0] IF_INSTR;
`ifdef PC_MISALIGN_TRAP_EN
    logic              MISALIGN_TRAP;
`endif

    modport master (
`ifdef PC_MISALIGN_TRAP_EN
        output MISALIGN_TRAP,
`endif
        output PC, IMEM_READ, IMEM_ADDR, IF_VALID, IF_PC, IF_INSTR,
        input  PC_PLUS4, BRANCH_TARGET, BRANCH_TAKEN, STALL,
        input  IMEM_BUSYWAIT, IMEM_RDATA
    );

    modport slave (
`ifdef PC_MISALIGN_TRAP_EN
        input  MISALIGN_TRAP,
`endif
        input  PC, IMEM_READ, IMEM_ADDR, IF_VALID, IF_PC, IF_INSTR,
        output PC_PLUS4, BRANCH_TARGET, BRANCH_TAKEN, STALL,
        output IMEM_BUSYWAIT, IMEM_RDATA
    );

endinterface

// File: rtl/pc_fetch_unit_redirect_ctrl.sv
// Redirect bookkeeping for the fetch unit. A branch arriving while memory is
// busy cannot move the PC yet, so its target is parked until the memory
// answers; the answer is then dropped and the parked target loaded. The
// youngest branch always wins. With PC_MISALIGN_TRAP_EN a misaligned target
// is replaced by TRAP_VECTOR and flagged; without it the low bits are cleared.
module pc_redirect_ctrl
    import pc_fetch_defs::*;
#(
    parameter logic [WORD_W-1:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  fetch_state_t      state,
    input  logic              busywait,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    output logic              redirect,
    output logic [WORD_W-1:0] redirect_pc,
`ifdef PC_MISALIGN_TRAP_EN
    output logic              trap,
`endif
    output logic              squash
);

    logic              pending;
    logic [WORD_W-1:0] held_pc;
    logic [WORD_W-1:0] fresh_pc;

`ifdef PC_MISALIGN_TRAP_EN
    logic held_trap;
    logic fresh_trap;

    assign fresh_trap = |branch_target[1:0];
    assign fresh_pc   = fresh_trap ? TRAP_VECTOR : branch_target;
    assign trap       = squash & (branch_taken ? fresh_trap : held_trap);
`else
    logic unused_bits;

    assign fresh_pc    = {branch_target[WORD_W-1:2], 2'b00};
    assign unused_bits = ^{TRAP_VECTOR, branch_target[1:0]};
`endif

    assign redirect    = branch_taken | pending;
    assign redirect_pc = branch_taken ? fresh_pc : held_pc;
    // Outside WAIT a branch acts at once; inside WAIT it acts only when the
    // memory answer arrives (that answer is the word being thrown away).
    assign squash      = (state == S_WAIT) ? (redirect & ~busywait) : branch_taken;

    // Park a branch target that arrives while memory is busy; clear once applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            held_pc <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            held_trap <= 1'b0;
`endif
        end else if (squash) begin
            pending <= 1'b0;
        end else if (state == S_WAIT && branch_taken) begin
            pending <= 1'b1;
            held_pc <= fresh_pc;
`ifdef PC_MISALIGN_TRAP_EN
            held_trap <= fresh_trap;
`endif
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, instruction-memory busy-wait handshake and the
// {PC, instruction} hand-off to the IF/ID register. A word captured while the
// stage is stalled is parked in IF_PC/IF_INSTR with IF_VALID low and released
// as a one-cycle IF_VALID pulse when the stall lifts. Optional feature macro:
// PC_MISALIGN_TRAP_EN (adds MISALIGN_TRAP and trap redirection).
module pc_fetch_unit
    import pc_fetch_defs::*;
#(
    parameter logic [WORD_W-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WORD_W-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic           CLK,
    input  logic           RESET,
    pc_fetch_unit_if.master bus
);

    fetch_state_t      state;
    logic [WORD_W-1:0] pc;
    logic              read;
    logic              if_valid;
    logic [WORD_W-1:0] if_pc;
    logic [WORD_W-1:0] if_instr;

    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic              squash;
    logic [WORD_W-1:0] next_pc;
    logic              unused_nop;

    assign unused_nop = ^INSTR_NOP;

`ifdef PC_MISALIGN_TRAP_EN
    logic trap;
    logic misalign_trap;
`endif

    pc_redirect_ctrl #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_redirect (
        .clk           (CLK),
        .rst_n         (RESET),
        .state         (state),
        .busywait      (bus.IMEM_BUSYWAIT),
        .branch_taken  (bus.BRANCH_TAKEN),
        .branch_target (bus.BRANCH_TARGET),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
`ifdef PC_MISALIGN_TRAP_EN
        .trap          (trap),
`endif
        .squash        (squash)
    );

    assign next_pc = redirect ? redirect_pc : bus.PC_PLUS4;

    // Sequence the memory handshake, advance the PC and hand words to IF/ID.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_FETCH;
            pc       <= RESET_VECTOR;
            read     <= 1'b0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
        end else begin
            if_valid <= 1'b0;
            if (squash) begin
                // Redirect wins over everything, including a stall; the word
                // in flight or parked is dropped.
                pc    <= next_pc;
                state <= S_FETCH;
                read  <= 1'b1;
            end else begin
                case (state)
                    S_FETCH, S_WAIT: begin
                        if (!read) begin
                            // First cycle after reset: start requesting.
                            read <= 1'b1;
                        end else if (bus.IMEM_BUSYWAIT) begin
                            state <= S_WAIT;
                        end else begin
                            if_pc    <= pc;
                            if_instr <= bus.IMEM_RDATA;
                            if (bus.STALL) begin
                                state <= S_HOLD;
                                read  <= 1'b0;
                            end else begin
                                if_valid <= 1'b1;
                                pc       <= next_pc;
                                state    <= S_FETCH;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!bus.STALL) begin
                            if_valid <= 1'b1;
                            pc       <= next_pc;
                            state    <= S_FETCH;
                            read     <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_FETCH;
                        read  <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // One-cycle trap flag for a redirect that was diverted to TRAP_VECTOR.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            misalign_trap <= 1'b0;
        end else begin
            misalign_trap <= trap;
        end
    end

    assign bus.MISALIGN_TRAP = misalign_trap;
`endif

    assign bus.PC        = pc;
    assign bus.IMEM_ADDR = pc;
    assign bus.IMEM_READ = read;
    assign bus.IF_VALID  = if_valid;
    assign bus.IF_PC     = if_pc;
    assign bus.IF_INSTR  = if_instr;

endmodule
